// File: rtl/mole_io_pkg.sv
// Shared types and constants for the mole button input conditioner.
// Channel state encodings, default debounce timing and press counter width.
package mole_io_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } mole_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int CNT_W_DEF           = 20;
    localparam int PRESS_TOTAL_W       = 16;

    // Add with clamp to all-ones instead of wrapping.
    function automatic logic [PRESS_TOTAL_W-1:0] sat_add(
        input logic [PRESS_TOTAL_W-1:0] a,
        input logic [PRESS_TOTAL_W-1:0] b
    );
        logic [PRESS_TOTAL_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PRESS_TOTAL_W] ? {PRESS_TOTAL_W{1'b1}} : sum[PRESS_TOTAL_W-1:0];
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter, debounce FSM, level and press pulse.
// MOLE_INPUT_ACTIVE_LOW_EN: raw pin is active-low; inverted after the synchroniser, sync flops reset to 1.
//
//   state           | meaning
//   ----------------+-----------------------------------------------------------
//   ST_RELEASED     | level 0, synced input idle
//   ST_PRESS_PEND   | level 0, synced input pressed, counting stable cycles
//   ST_PRESSED      | level 1, synced input pressed
//   ST_RELEASE_PEND | level 1, synced input released, counting stable cycles
module debounce_channel
    import mole_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clock,
    input  logic ctrl_reset_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

`ifdef MOLE_INPUT_ACTIVE_LOW_EN
    localparam logic SYNC_RST = 1'b1;
`else
    localparam logic SYNC_RST = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             pressed;
    mole_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_d, pulse_d;

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            sync_q <= {2{SYNC_RST}};
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

`ifdef MOLE_INPUT_ACTIVE_LOW_EN
    assign pressed = ~sync_q[1];
`else
    assign pressed = sync_q[1];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RELEASED: begin
                if (pressed) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_PRESS_PEND;
                end
            end
            ST_PRESS_PEND: begin
                if (!pressed) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASED;
                end else if (cnt_q == CNT_TERM) begin
                    cnt_d   = '0;
                    state_d = ST_PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!pressed) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_RELEASE_PEND;
                end
            end
            ST_RELEASE_PEND: begin
                if (pressed) begin
                    cnt_d   = '0;
                    state_d = ST_PRESSED;
                end else if (cnt_q == CNT_TERM) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_RELEASED;
            end
        endcase
    end

    // Level and pulse are registered from the next state so they align with the state change.
    assign level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_PEND);
    assign pulse_d = (state_q == ST_PRESS_PEND) && (state_d == ST_PRESSED);

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
            pulse   <= pulse_d;
        end
    end

endmodule

// File: rtl/mole_input_conditioner.sv
// Eight-button front end: per-channel debounce, press pulses, press_any and saturating press_total.
// MOLE_INPUT_ACTIVE_LOW_EN selects active-low raw pins inside each debounce_channel.
module mole_input_conditioner
    import mole_io_pkg::*;
#(
    parameter int NUM_MOLES       = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                     clock,
    input  logic                     ctrl_reset_n,
    input  logic [NUM_MOLES-1:0]     JA_raw,
    output logic [NUM_MOLES-1:0]     JA,
    output logic [NUM_MOLES-1:0]     press_pulse,
    output logic                     press_any,
    output logic [PRESS_TOTAL_W-1:0] press_total,
    input  logic                     clear_total
);

    logic [PRESS_TOTAL_W-1:0] pulse_count;

    for (genvar g = 0; g < NUM_MOLES; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clock       (clock),
            .ctrl_reset_n(ctrl_reset_n),
            .raw         (JA_raw[g]),
            .level       (JA[g]),
            .pulse       (press_pulse[g])
        );
    end

    assign press_any = |press_pulse;

    always_comb begin
        pulse_count = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            pulse_count = pulse_count + PRESS_TOTAL_W'(press_pulse[i]);
        end
    end

    // Clear wins over the add, so pulses in a clearing cycle are not counted.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            press_total <= '0;
        end else if (clear_total) begin
            press_total <= '0;
        end else begin
            press_total <= sat_add(press_total, pulse_count);
        end
    end

endmodule
